// File: rtl/arb_pkg.sv
// Shared types and default parameters for the arbiter requester client.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } arb_req_state_t;

  localparam int ARB_LEN_W        = 8;
  localparam int ARB_STARVE_LIMIT = 255;
  localparam int ARB_STARVE_W     = 8;
  localparam int ARB_PCNT_W       = 8;

endpackage

// File: rtl/arb_sat_cnt.sv
// Up-counter that sticks at MAX; clr wins over inc.
module arb_sat_cnt #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Requester-side client for a fixed-priority arbiter port: requests, counts
// granted beats, rides out preemption and flags starvation.
//
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a burst command
//   ARB   | requesting, no grant yet (first granted beat may fire here)
//   XFER  | granted, beats flowing
//   DONE  | one-cycle done pulse
module arb_requester
  import arb_pkg::*;
#(
  parameter int LEN_W        = ARB_LEN_W,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
  parameter int STARVE_W     = ARB_STARVE_W,
  parameter int PCNT_W       = ARB_PCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              req,
  input  logic              grant,
  output logic              beat_valid,
  output logic [LEN_W-1:0]  beat_idx,
  output logic              beat_last,
  output logic              done,
  output logic [PCNT_W-1:0] preempt_cnt,
  output logic              starve
);

  arb_req_state_t state, state_nxt;
  logic [LEN_W-1:0]    remaining;
  logic [STARVE_W-1:0] wait_cnt;
  logic busy, last, accept;

  assign busy   = (state == ARB) || (state == XFER);
  assign last   = (remaining == LEN_W'(1));
  assign accept = (state == IDLE) && cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A granted last beat ends the burst from ARB as well as XFER (1-beat case).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = (cmd_len == '0) ? DONE : ARB;
      ARB:  if (grant)     state_nxt = last ? DONE : XFER;
      XFER: begin
        if (!grant)    state_nxt = ARB;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req drops during the last beat so the arbiter does not grant a dead cycle.
  always_comb begin
    cmd_ready  = (state == IDLE);
    req        = busy && !(grant && last);
    beat_valid = busy && grant;
    beat_last  = busy && grant && last;
    done       = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      beat_idx  <= '0;
    end else if (accept) begin
      remaining <= cmd_len;
      beat_idx  <= '0;
    end else if (beat_valid) begin
      remaining <= remaining - 1'b1;
      beat_idx  <= beat_idx + 1'b1;
    end
  end

  arb_sat_cnt #(
    .WIDTH (PCNT_W),
    .MAX   ((1 << PCNT_W) - 1)
  ) u_preempt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state == XFER) && !grant),
    .clr   (accept),
    .cnt   (preempt_cnt)
  );

  arb_sat_cnt #(
    .WIDTH (STARVE_W),
    .MAX   (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state == ARB) && !grant),
    .clr   ((state == IDLE) || grant),
    .cnt   (wait_cnt)
  );

  assign starve = (wait_cnt >= STARVE_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench: 4-port lowest-index-wins arbiter, DUT on port 2, bench on ports 0/1.
module tb_arb_requester;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_len;
  logic       req;
  logic       beat_valid;
  logic [7:0] beat_idx;
  logic       beat_last;
  logic       done;
  logic [1:0] preempt_cnt;
  logic       starve;
  logic       p0, p1;
  logic [3:0] req_vec, gnt;

  int n_checks = 0;
  int n_err    = 0;

  arb_requester #(
    .LEN_W        (8),
    .STARVE_LIMIT (8),
    .STARVE_W     (8),
    .PCNT_W       (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .req         (req),
    .grant       (gnt[2]),
    .beat_valid  (beat_valid),
    .beat_idx    (beat_idx),
    .beat_last   (beat_last),
    .done        (done),
    .preempt_cnt (preempt_cnt),
    .starve      (starve)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign req_vec = {1'b0, req, p1, p0};

  // Registered grant: lowest set request bit wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gnt <= '0;
    else        gnt <= req_vec & (~req_vec + 4'd1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command in this cycle (cycle 0 of the burst).
  task automatic issue(input string tag, input logic [7:0] len);
    @(negedge clk);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_req0"}, 32'(req), 32'd0);
    cmd_valid = 1'b1;
    cmd_len   = len;
  endtask

  // One burst cycle: drive bench ports, check {req,beat_valid,beat_last,done,cmd_ready}.
  task automatic cyc(input string tag, input int k, input logic p0v, input logic p1v,
                     input logic [4:0] e, input logic [7:0] ei);
    @(negedge clk);
    cmd_valid = 1'b0;
    p0 = p0v;
    p1 = p1v;
    check($sformatf("%s_c%0d_flags", tag, k),
          32'({req, beat_valid, beat_last, done, cmd_ready}), 32'(e));
    if (e[3]) check($sformatf("%s_c%0d_idx", tag, k), 32'(beat_idx), 32'(ei));
  endtask

  initial begin
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    p0        = 1'b0;
    p1        = 1'b0;
    #2 rst_n  = 1'b0;

    @(negedge clk);
    check("rst_req",     32'(req), 32'd0);
    check("rst_bv",      32'(beat_valid), 32'd0);
    check("rst_last",    32'(beat_last), 32'd0);
    check("rst_done",    32'(done), 32'd0);
    check("rst_starve",  32'(starve), 32'd0);
    check("rst_preempt", 32'(preempt_cnt), 32'd0);
    check("rst_idx",     32'(beat_idx), 32'd0);
    rst_n = 1'b1;

    // Uncontested 4-beat burst
    issue("unc", 8'd4);
    cyc("unc", 1, 0, 0, 5'b10000, 8'd0);
    cyc("unc", 2, 0, 0, 5'b11000, 8'd0);
    cyc("unc", 3, 0, 0, 5'b11000, 8'd1);
    cyc("unc", 4, 0, 0, 5'b11000, 8'd2);
    cyc("unc", 5, 0, 0, 5'b01100, 8'd3);
    cyc("unc", 6, 0, 0, 5'b00010, 8'd0);
    check("unc_preempt", 32'(preempt_cnt), 32'd0);
    cyc("unc", 7, 0, 0, 5'b00001, 8'd0);

    // 5-beat burst, port 0 requests in cycles 3..4
    issue("pre", 8'd5);
    cyc("pre", 1, 0, 0, 5'b10000, 8'd0);
    cyc("pre", 2, 0, 0, 5'b11000, 8'd0);
    cyc("pre", 3, 1, 0, 5'b11000, 8'd1);
    cyc("pre", 4, 1, 0, 5'b10000, 8'd0);
    cyc("pre", 5, 0, 0, 5'b10000, 8'd0);
    cyc("pre", 6, 0, 0, 5'b11000, 8'd2);
    cyc("pre", 7, 0, 0, 5'b11000, 8'd3);
    cyc("pre", 8, 0, 0, 5'b01100, 8'd4);
    cyc("pre", 9, 0, 0, 5'b00010, 8'd0);
    check("pre_preempt", 32'(preempt_cnt), 32'd1);
    cyc("pre", 10, 0, 0, 5'b00001, 8'd0);

    // Starvation: port 1 holds the bus for cycles 1..10
    p1 = 1'b1;
    issue("stv", 8'd2);
    for (int k = 1; k <= 8; k++) begin
      cyc("stv", k, 0, 1, 5'b10000, 8'd0);
      check($sformatf("stv_c%0d_starve", k), 32'(starve), 32'd0);
    end
    cyc("stv", 9, 0, 1, 5'b10000, 8'd0);
    check("stv_c9_starve", 32'(starve), 32'd1);
    cyc("stv", 10, 0, 0, 5'b10000, 8'd0);
    check("stv_c10_starve", 32'(starve), 32'd1);
    cyc("stv", 11, 0, 0, 5'b11000, 8'd0);
    cyc("stv", 12, 0, 0, 5'b01100, 8'd1);
    check("stv_c12_starve", 32'(starve), 32'd0);
    cyc("stv", 13, 0, 0, 5'b00010, 8'd0);
    cyc("stv", 14, 0, 0, 5'b00001, 8'd0);

    // Empty command, then a 1-beat command back to back
    issue("emp", 8'd0);
    cyc("emp", 1, 0, 0, 5'b00010, 8'd0);
    issue("one", 8'd1);
    cyc("one", 1, 0, 0, 5'b10000, 8'd0);
    cyc("one", 2, 0, 0, 5'b01100, 8'd0);
    cyc("one", 3, 0, 0, 5'b00010, 8'd0);
    cyc("one", 4, 0, 0, 5'b00001, 8'd0);

    // Reset in the middle of a 6-beat burst, during the third beat
    issue("rmb", 8'd6);
    cyc("rmb", 1, 0, 0, 5'b10000, 8'd0);
    cyc("rmb", 2, 0, 0, 5'b11000, 8'd0);
    cyc("rmb", 3, 0, 0, 5'b11000, 8'd1);
    cyc("rmb", 4, 0, 0, 5'b11000, 8'd2);
    rst_n = 1'b0;
    #1;
    check("rmb_req",  32'(req), 32'd0);
    check("rmb_bv",   32'(beat_valid), 32'd0);
    check("rmb_last", 32'(beat_last), 32'd0);
    check("rmb_idx",  32'(beat_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rmb_ready", 32'(cmd_ready), 32'd1);
    issue("rst2", 8'd3);
    cyc("rst2", 1, 0, 0, 5'b10000, 8'd0);
    cyc("rst2", 2, 0, 0, 5'b11000, 8'd0);
    cyc("rst2", 3, 0, 0, 5'b11000, 8'd1);
    cyc("rst2", 4, 0, 0, 5'b01100, 8'd2);
    cyc("rst2", 5, 0, 0, 5'b00010, 8'd0);
    cyc("rst2", 6, 0, 0, 5'b00001, 8'd0);

    // Five preemptions in a 6-beat burst; 2-bit counter sticks at 3
    issue("sat", 8'd6);
    cyc("sat", 1,  0, 0, 5'b10000, 8'd0);
    cyc("sat", 2,  1, 0, 5'b11000, 8'd0);
    cyc("sat", 3,  0, 0, 5'b10000, 8'd0);
    cyc("sat", 4,  1, 0, 5'b11000, 8'd1);
    cyc("sat", 5,  0, 0, 5'b10000, 8'd0);
    cyc("sat", 6,  1, 0, 5'b11000, 8'd2);
    check("sat_c6_preempt", 32'(preempt_cnt), 32'd2);
    cyc("sat", 7,  0, 0, 5'b10000, 8'd0);
    cyc("sat", 8,  1, 0, 5'b11000, 8'd3);
    cyc("sat", 9,  0, 0, 5'b10000, 8'd0);
    cyc("sat", 10, 1, 0, 5'b11000, 8'd4);
    cyc("sat", 11, 0, 0, 5'b10000, 8'd0);
    cyc("sat", 12, 0, 0, 5'b01100, 8'd5);
    cyc("sat", 13, 0, 0, 5'b00010, 8'd0);
    check("sat_c13_preempt", 32'(preempt_cnt), 32'd3);
    cyc("sat", 14, 0, 0, 5'b00001, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
